// File: rtl/riio_pwr_seq_pkg.sv
// Shared types and parameter helpers for the pad-ring power sequencer.
package riio_pwr_seq_pkg;

  typedef enum logic [3:0] {
    OFF,
    UP_EN,
    UP_WAIT,
    ISO_REL,
    ON,
    ISO_SET,
    DN_DIS,
    DN_WAIT,
    ERR
  } state_e;

  localparam int N_GRP_MAX = 16;

  function automatic int GRP_IDX_W(input int n_grp);
    return (n_grp > 1) ? $clog2(n_grp) : 1;
  endfunction

  function automatic bit params_ok(input int n_grp, input int settle_cyc,
                                   input int timeout_cyc, input int sync_stages);
    return (n_grp >= 1) && (n_grp <= N_GRP_MAX) && (settle_cyc >= 1) &&
           (timeout_cyc > settle_cyc) && (sync_stages >= 2);
  endfunction

endpackage

// File: rtl/riio_sync_cell.sv
// Multi-flop synchroniser for asynchronous level inputs; resets to 0.
module riio_sync_cell #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sync_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/riio_pad_pwr_seq.sv
// Pad-ring supply-group power sequencer; optional isolation phases with RIIO_PWR_SEQ_ISO_EN.
//  state   | meaning
//  OFF     | all groups off, waiting for req_on
//  UP_EN   | close switch of group idx
//  UP_WAIT | settle, then wait for pg of group idx high
//  ISO_REL | release isolation of group idx (iso build only)
//  ON      | all groups on and good, watching for pg loss
//  ISO_SET | clamp isolation of group idx (iso build only)
//  DN_DIS  | open switch of group idx
//  DN_WAIT | settle, then wait for pg of group idx low
//  ERR     | emergency off, waiting for req_on low
module riio_pad_pwr_seq
  import riio_pwr_seq_pkg::*;
#(
  parameter int N_GRP       = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_on,
  input  logic [N_GRP-1:0]             pg_i,
  output logic [N_GRP-1:0]             sw_en_o,
`ifdef RIIO_PWR_SEQ_ISO_EN
  output logic [N_GRP-1:0]             iso_o,
`endif
  output logic                         busy_o,
  output logic                         ready_o,
  output logic                         err_o,
  output logic [GRP_IDX_W(N_GRP)-1:0]  err_grp_o
);

  localparam int IW = GRP_IDX_W(N_GRP);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_GRP - 1);
  // Remaining-cycle value at which SETTLE_CYC-1 cycles have elapsed since the switch edge.
  localparam logic [TW-1:0] SETTLE_TC = TW'(TIMEOUT_CYC - SETTLE_CYC + 1);

`ifdef RIIO_PWR_SEQ_ISO_EN
  localparam state_e DN_ENTRY = ISO_SET;
`else
  localparam state_e DN_ENTRY = DN_DIS;
`endif

  if (!params_ok(N_GRP, SETTLE_CYC, TIMEOUT_CYC, SYNC_STAGES)) begin : g_param_chk
    $error("riio_pad_pwr_seq: parameter out of range");
  end

  state_e           state_q;
  logic [IW-1:0]    idx_q;
  logic [N_GRP-1:0] sw_en_q;
  logic             busy_q;
  logic             ready_q;
  logic             err_q;
  logic [IW-1:0]    err_grp_q;
  logic             req_q;
  logic [TW-1:0]    tmr_q;
  logic [N_GRP-1:0] pg_s;
  logic             settle_done;
  logic             tmo;
`ifdef RIIO_PWR_SEQ_ISO_EN
  logic [N_GRP-1:0] iso_q;
`endif

  riio_sync_cell #(
    .W      (N_GRP),
    .STAGES (SYNC_STAGES)
  ) u_pg_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pg_i),
    .q_o (pg_s)
  );

  function automatic logic [IW-1:0] lowest_low(input logic [N_GRP-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = N_GRP - 1; i >= 0; i--) begin
      if (!v[i]) r = IW'(i);
    end
    return r;
  endfunction

  // Down-counter reloaded on every switch edge; holds at zero once the timeout has passed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q <= '0;
    end else if (state_q == UP_EN || state_q == DN_DIS) begin
      tmr_q <= TW'(TIMEOUT_CYC);
    end else if (tmr_q != '0) begin
      tmr_q <= tmr_q - TW'(1);
    end
  end

  assign settle_done = (tmr_q <= SETTLE_TC);
  assign tmo         = (tmr_q == TW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= OFF;
      idx_q     <= '0;
      sw_en_q   <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      err_grp_q <= '0;
      req_q     <= 1'b0;
`ifdef RIIO_PWR_SEQ_ISO_EN
      iso_q     <= '1;
`endif
    end else begin
      req_q <= req_on;
      case (state_q)
        OFF: begin
          if (req_q) begin
            state_q <= UP_EN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        UP_EN: begin
          if (!req_q) begin
            state_q <= DN_ENTRY;
          end else begin
            sw_en_q[idx_q] <= 1'b1;
            state_q        <= UP_WAIT;
          end
        end
        UP_WAIT: begin
          if (!req_q) begin
            state_q <= DN_ENTRY;
          end else if (settle_done && pg_s[idx_q]) begin
`ifdef RIIO_PWR_SEQ_ISO_EN
            state_q <= ISO_REL;
`else
            if (idx_q == LAST_IDX) begin
              state_q <= ON;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= UP_EN;
            end
`endif
          end else if (tmo) begin
            state_q   <= ERR;
            sw_en_q   <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b1;
            err_grp_q <= idx_q;
`ifdef RIIO_PWR_SEQ_ISO_EN
            iso_q     <= '1;
`endif
          end
        end
`ifdef RIIO_PWR_SEQ_ISO_EN
        ISO_REL: begin
          if (!req_q) begin
            state_q <= ISO_SET;
          end else begin
            iso_q[idx_q] <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q <= ON;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= UP_EN;
            end
          end
        end
        ISO_SET: begin
          iso_q[idx_q] <= 1'b1;
          state_q      <= DN_DIS;
        end
`endif
        ON: begin
          if (!req_q) begin
            state_q <= DN_ENTRY;
            idx_q   <= LAST_IDX;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end else if (~&pg_s) begin
            state_q   <= ERR;
            sw_en_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b1;
            err_grp_q <= lowest_low(pg_s);
`ifdef RIIO_PWR_SEQ_ISO_EN
            iso_q     <= '1;
`endif
          end
        end
        DN_DIS: begin
          sw_en_q[idx_q] <= 1'b0;
          state_q        <= DN_WAIT;
        end
        DN_WAIT: begin
          if (settle_done && !pg_s[idx_q]) begin
            if (idx_q == '0) begin
              state_q <= OFF;
              busy_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q - IW'(1);
              state_q <= DN_ENTRY;
            end
          end else if (tmo) begin
            state_q   <= ERR;
            sw_en_q   <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b1;
            err_grp_q <= idx_q;
`ifdef RIIO_PWR_SEQ_ISO_EN
            iso_q     <= '1;
`endif
          end
        end
        ERR: begin
          if (!req_q) begin
            state_q <= OFF;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= OFF;
        end
      endcase
    end
  end

  assign sw_en_o   = sw_en_q;
  assign busy_o    = busy_q;
  assign ready_o   = ready_q;
  assign err_o     = err_q;
  assign err_grp_o = err_grp_q;
`ifdef RIIO_PWR_SEQ_ISO_EN
  assign iso_o     = iso_q;
`endif

endmodule

// File: tb/tb_riio_pad_pwr_seq.sv
// Scoreboard bench for riio_pad_pwr_seq: randomized pad delays and scenarios vs. an event-level model.
module tb_riio_pad_pwr_seq;

  localparam int N  = 4;
  localparam int S  = 16;
  localparam int T  = 64;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_on = 1'b0;
  logic [N-1:0] pg_i = '0;
  logic [N-1:0] sw_en_o;
  logic         busy_o;
  logic         ready_o;
  logic         err_o;
  logic [1:0]   err_grp_o;
`ifdef RIIO_PWR_SEQ_ISO_EN
  logic [N-1:0] iso_o;
`endif

  riio_pad_pwr_seq #(
    .N_GRP       (N),
    .SETTLE_CYC  (S),
    .TIMEOUT_CYC (T),
    .SYNC_STAGES (SS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_on    (req_on),
    .pg_i      (pg_i),
    .sw_en_o   (sw_en_o),
`ifdef RIIO_PWR_SEQ_ISO_EN
    .iso_o     (iso_o),
`endif
    .busy_o    (busy_o),
    .ready_o   (ready_o),
    .err_o     (err_o),
    .err_grp_o (err_grp_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad model: each pg follows its switch enable d[g] cycles later, with forced-low overrides.
  int           d [N] = '{default: 1};
  logic [31:0]  hist [N] = '{default: '0};
  logic [N-1:0] hold_low = '0;
  logic [N-1:0] pulse_low = '0;

  always @(posedge clk) begin
    #1;
    for (int g = 0; g < N; g++) begin
      hist[g]  = {hist[g][30:0], sw_en_o[g]};
      pg_i[g]  = hist[g][d[g]] & ~hold_low[g] & ~pulse_low[g];
    end
  end

  typedef struct {
    logic [N-1:0] sw;
    logic         busy;
    logic         ready;
    logic         err;
    logic [1:0]   grp;
    int           dly;
    bit           from_stim;
  } ev_t;

  ev_t          q[$];
  int           tests = 0;
  int           fails = 0;
  int           stim_cyc = 0;
  int           last_cyc = 0;
  bit           mon_en = 1'b0;
  logic [N+4:0] last_snap = '0;

  function automatic void push(input logic [N-1:0] sw, input logic busy, input logic ready,
                               input logic err, input int grp, input int dly, input bit fs);
    ev_t e;
    e.sw = sw; e.busy = busy; e.ready = ready; e.err = err;
    e.grp = 2'(grp); e.dly = dly; e.from_stim = fs;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin : monitor
    logic [N+4:0] cur;
    logic [N+4:0] exp_s;
    ev_t          e;
    int           act_dly;
    if (mon_en) begin
      cur = {sw_en_o, busy_o, ready_o, err_o, (err_o ? err_grp_o : 2'b00)};
      if (cur !== last_snap) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got sw=%b busy=%b ready=%b err=%b grp=%0d at cycle %0d, required no change",
                   sw_en_o, busy_o, ready_o, err_o, err_grp_o, cyc);
        end else begin
          e = q.pop_front();
          act_dly = e.from_stim ? (cyc - stim_cyc) : (cyc - last_cyc);
          exp_s = {e.sw, e.busy, e.ready, e.err, (e.err ? e.grp : 2'b00)};
          if (cur !== exp_s || (e.dly >= 0 && act_dly != e.dly)) begin
            fails++;
            $display("FAIL event: got sw=%b busy=%b ready=%b err=%b grp=%0d dly=%0d, required sw=%b busy=%b ready=%b err=%b grp=%0d dly=%0d",
                     sw_en_o, busy_o, ready_o, err_o, err_grp_o, act_dly,
                     e.sw, e.busy, e.ready, e.err, e.grp, e.dly);
          end
        end
        last_snap = cur;
        last_cyc  = cyc;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d events pending, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic stim_req(input logic v);
    req_on   = v;
    stim_cyc = cyc;
  endtask

  task automatic rand_d(input int maxd);
    for (int g = 0; g < N; g++) d[g] = $urandom_range(maxd, 1);
  endtask

  // Cycles a wait phase lasts: the settle window or the synchronised pg arrival, whichever is later.
  function automatic int stepd(input int g);
    return (S > d[g] + SS + 1) ? S : d[g] + SS + 1;
  endfunction

  function automatic int lowest(input logic [N-1:0] m);
    for (int g = 0; g < N; g++) if (m[g]) return g;
    return 0;
  endfunction

  // Up sequence events; f = group whose pg never rises (N: none); stop after group upto is switched on.
  task automatic push_up(input int f, input bit fs, input int upto);
    logic [N-1:0] sw;
    sw = '0;
    if (fs) push(sw, 1, 0, 0, 0, 2, 1);
    else    push(sw, 1, 0, 0, 0, 1, 0);
    sw[0] = 1'b1;
    push(sw, 1, 0, 0, 0, 1, 0);
    for (int g = 0; g < N; g++) begin
      if (g == upto) return;
      if (g == f) begin
        push('0, 0, 0, 1, g, T, 0);
        return;
      end
      if (g == N - 1) begin
        push(sw, 0, 1, 0, 0, stepd(g), 0);
      end else begin
        sw[g+1] = 1'b1;
        push(sw, 1, 0, 0, 0, stepd(g) + 1, 0);
      end
    end
  endtask

  // Down sequence events starting with group top; abort = entered from an up phase.
  task automatic push_down(input int top, input bit abort);
    logic [N-1:0] sw;
    sw = '0;
    for (int g = 0; g <= top; g++) sw[g] = 1'b1;
    if (!abort) push(sw, 1, 0, 0, 0, 2, 1);
    sw[top] = 1'b0;
    push(sw, 1, 0, 0, 0, abort ? 3 : 1, abort);
    for (int g = top; g >= 1; g--) begin
      sw[g-1] = 1'b0;
      push(sw, 1, 0, 0, 0, stepd(g) + 1, 0);
    end
    push('0, 0, 0, 0, 0, stepd(0), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int           a;
    int           f;
    logic [N-1:0] m;

    #3 rst = 1'b1;
    #1;
    check("rst_sw_en", 32'(sw_en_o), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);
    check("reset_sw_en", 32'(sw_en_o), 32'h0);
    check("reset_busy", 32'(busy_o), 32'h0);
    check("reset_ready", 32'(ready_o), 32'h0);
    check("reset_err", 32'(err_o), 32'h0);
    check("reset_err_grp", 32'(err_grp_o), 32'h0);
`ifdef RIIO_PWR_SEQ_ISO_EN
    check("reset_iso", 32'(iso_o), 32'hf);
`endif
    last_snap = '0;
    mon_en    = 1'b1;

    for (int it = 0; it < 6; it++) begin
      // Full power-up, then a plain down, a down with req re-raised, or a pg loss.
      rand_d(20);
      stim_req(1'b1);
      push_up(N, 1, N);
      wait_drain(600);
      case (it % 3)
        0: begin
          idle($urandom_range(5, 1));
          stim_req(1'b0);
          push_down(N - 1, 0);
          wait_drain(600);
        end
        1: begin
          stim_req(1'b0);
          push_down(N - 1, 0);
          push_up(N, 0, N);
          idle(4);
          req_on = 1'b1;
          wait_drain(1200);
          stim_req(1'b0);
          push_down(N - 1, 0);
          wait_drain(600);
        end
        default: begin
          idle($urandom_range(20, 1));
          m = N'($urandom_range(15, 1));
          pulse_low = m;
          stim_cyc  = cyc;
          push('0, 0, 0, 1, lowest(m), 4, 1);
          idle(3);
          pulse_low = '0;
          wait_drain(100);
          stim_req(1'b0);
          push('0, 0, 0, 0, 0, 2, 1);
          wait_drain(100);
        end
      endcase
      idle(40);

      // Up timeout on a random group.
      rand_d(12);
      f = $urandom_range(N - 1, 0);
      hold_low[f] = 1'b1;
      stim_req(1'b1);
      push_up(f, 1, N);
      wait_drain(600);
      stim_req(1'b0);
      push('0, 0, 0, 0, 0, 2, 1);
      wait_drain(100);
      hold_low = '0;
      idle(40);

      // Abort while waiting on group a.
      rand_d(12);
      a = $urandom_range(N - 1, 0);
      stim_req(1'b1);
      push_up(N, 1, a);
      wait_drain(600);
      idle($urandom_range(8, 1));
      stim_req(1'b0);
      push_down(a, 1);
      wait_drain(600);
      idle(40);

      // Asynchronous reset in the middle of an up wait.
      rand_d(12);
      a = $urandom_range(N - 1, 0);
      stim_req(1'b1);
      push_up(N, 1, a);
      wait_drain(600);
      idle($urandom_range(8, 1));
      #1;
      push('0, 0, 0, 0, 0, -1, 0);
      rst    = 1'b1;
      req_on = 1'b0;
      #1;
      check("async_rst_sw_en", 32'(sw_en_o), 32'h0);
      check("async_rst_busy", 32'(busy_o), 32'h0);
`ifdef RIIO_PWR_SEQ_ISO_EN
      check("async_rst_iso", 32'(iso_o), 32'hf);
`endif
      idle(2);
      rst = 1'b0;
      wait_drain(10);
      idle(40);
    end

    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL leftover_events: got %0d pending, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
